func_rate1_stream: RTL
======================

# func_rate1_stream

Multi-cycle Rate-1 node processor for the fast-SSC polar decoder. It takes a Rate-1 node of 2^`node_log2` LLRs, delivered `LANES` LLRs per beat from the LLR memory path, and makes a hard decision on each LLR (bit = sign). The decided bits go out one chunk per beat, in either bit-reversed or natural lane order, toward partial-sum/codeword memory. It also reports the parity of the whole node and a done pulse to the decoder scheduler.

## Interface
- `LLR_W`, 6, width of one internal LLR (two's complement).
- `LANES`, 16, LLRs per beat; power of two, ≥2.
- `MAX_NODE_LOG2`, 10, largest supported node size (log2).
- `NL_W`, $clog2(`MAX_NODE_LOG2`+1), width of `node_log2`.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: begin a node; sampled only in IDLE.
- `node_log2` in `NL_W`: node size (log2); sampled with `start`.
- `bitrev_en` in 1: 1 = bit-reversed lane order, 0 = natural; sampled with `start`.
- `llr_valid` in 1 / `llr_ready` out 1: input handshake.
- `llr` in `LANES*LLR_W`: lane 0 in the MSBs, lane `LANES-1` in the LSBs.
- `bit_valid` out 1 / `bit_ready` in 1: output handshake.
- `bit_out` out `LANES`: decided bits for one chunk.
- `bit_idx` out `MAX_NODE_LOG2`: chunk index of `bit_out`.
- `bit_last` out 1: final chunk of the node.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse after the final chunk is accepted downstream.
- `parity` out 1: XOR of all decided bits in the node; valid with `done`, held until the next `start`.
- `cfg_err` out 1: one-cycle pulse when `start` carries an illegal `node_log2`.

## Operation
- States: IDLE, RUN, FLUSH.
- **IDLE**
  - On `start` with log2(`LANES`) ≤ `node_log2` ≤ `MAX_NODE_LOG2`: latch `node_log2` and `bitrev_en`, load `chunks_left` = 2^(`node_log2` − log2 `LANES`), clear the parity accumulator and chunk counter, go to RUN.
  - On `start` with an illegal `node_log2`: pulse `cfg_err`, stay in IDLE.
- **RUN**
  - `llr_ready` = !`bit_valid` | `bit_ready`. The output register is one deep and passes through on ready.
  - On an input handshake:
    - `tmp[LANES-1-i]` = sign bit of lane i.
    - With `bitrev_en`=1: `bit_out[k]` = `tmp[bitrev(k)]` over log2(`LANES`) bits. For `LANES`=16 this gives {t15,t7,t11,t3,t13,t5,t9,t1,t14,t6,t10,t2,t12,t4,t8,t0}.
    - With `bitrev_en`=0: `bit_out` = `tmp`.
    - Register `bit_out`, set `bit_valid`, set `bit_idx` = chunk counter, and set `bit_last` when `chunks_left`==1.
    - Parity accumulator ^= XOR of `tmp`. Increment the counter, decrement `chunks_left`.
  - After the last input handshake: go to FLUSH.
- **FLUSH**
  - `llr_ready`=0.
  - When `bit_valid` & `bit_ready` & `bit_last`: pulse `done`, update `parity`, go to IDLE.
- `start` outside IDLE is ignored.
- Zero LLR is decided as bit 0; the most negative LLR is decided as 1.
- An output held with `bit_ready`=0 must keep `bit_out`, `bit_idx` and `bit_last` stable.
- Reset (any state, including mid-node):
  - state → IDLE.
  - `bit_valid`, `bit_last`, `done`, `cfg_err`, `parity`, `busy` → 0.
  - `bit_out` and `bit_idx` → 0.
  - `llr_ready` → 0.
  - Any partial node is discarded and no `done` is produced.

## Timing
- Latency input→output: 1 cycle (input handshake at cycle n → `bit_valid` at n+1).
- Throughput: 1 chunk per cycle while `bit_ready`=1.
- Minimum node time: chunks + 1 cycles from the first input handshake to `done`.
- `start` → `busy`=1 and `llr_ready` eligible on the next cycle.
- `done` → IDLE, so a new `start` is accepted in the cycle after `done`.
- Simultaneous output accept and new input in RUN: both occur in the same cycle, with no bubble.
- Single-chunk node (`node_log2` = log2 `LANES`): RUN lasts one handshake and the first output has `bit_last`=1.

## Structure
- The shared `defines.v` gains:
  - `LLR_INTERNAL_LEN` default for `LLR_W`;
  - `PROCESS_UNIT_LLR_NUM` default for `LANES`;
  - the state encodings `R1S_IDLE`, `R1S_RUN`, `R1S_FLUSH`.
- One sub-module: `rate1_hard_dec`. It is combinational sign extraction plus the optional bit-reversal permutation, built with a generate loop over `LANES` and a bit-reverse function.
- The FSM, counters, output register and parity accumulator live in the top module.

## Test plan
- **Single chunk, bit-reversed:** `LANES`=16, `node_log2`=4, `bitrev_en`=1, lane i = −1 only for i=0 (`tmp[15]`=1) → `bit_out`=0x8000, `bit_last`=1, `done` 2 cycles after the handshake, `parity`=1.
- **Permutation check:** only lane 8 negative (`tmp[7]`=1) → `bit_out`=0x4000 with `bitrev_en`=1, and 0x0080 with `bitrev_en`=0.
- **Multi-chunk with back-pressure:**
  - Setup: `node_log2`=6 (4 chunks), all LLRs negative, `bit_ready` low for 3 cycles on chunk 1.
  - Expected: `bit_idx` 0,1,2,3; outputs 0xFFFF; no data loss; `llr_ready` low while stalled; `parity`=0 (64 ones).
- **Illegal config:** `start` with `node_log2`=3 → `cfg_err` pulse, `busy` stays 0. Then `start` with `node_log2`=11 (`MAX`=10) → same result.
- **Reset mid-node:** `rst_n`=0 after 2 of 8 chunks → next cycle IDLE, all outputs 0, no `done`. A new 1-chunk node then completes normally.
- **Boundary values:** LLR = 0 → bit 0; LLR = −32 → bit 1; LLR = +31 → bit 0. Also `start` asserted while busy → ignored.

Source files
------------

// File: rtl/func_rate1_stream_pkg.sv
// Shared definitions for the Rate-1 node processor: default widths,
// FSM state encodings and the lane bit-reversal helper.
package func_rate1_stream_pkg;

  localparam int LLR_INTERNAL_LEN     = 6;
  localparam int PROCESS_UNIT_LLR_NUM = 16;

  typedef enum logic [1:0] {
    R1S_IDLE  = 2'd0,
    R1S_RUN   = 2'd1,
    R1S_FLUSH = 2'd2
  } r1s_state_e;

  // Reverse the low nbits of k (lane index permutation).
  function automatic int bitrev_idx(input int k, input int nbits);
    int r;
    r = 0;
    for (int b = 0; b < nbits; b++) begin
      r = (r << 1) | ((k >> b) & 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/func_rate1_stream_hard_dec.sv
// Combinational hard decision for one beat of LLRs: sign extraction per lane
// followed by an optional bit-reversal of the lane order.
module rate1_hard_dec
  import func_rate1_stream_pkg::*;
#(
  parameter int LLR_W = LLR_INTERNAL_LEN,
  parameter int LANES = PROCESS_UNIT_LLR_NUM
) (
  input  logic [LANES*LLR_W-1:0] llr,
  input  logic                   bitrev_en,
  output logic [LANES-1:0]       bits,
  output logic                   par
);

  localparam int LG = $clog2(LANES);

  logic [LANES-1:0] tmp;
  logic [LANES-1:0] tmp_rev;

  // Lane i sits in the MSB-side slice; its sign bit lands at tmp[LANES-1-i].
  // Zero decides to 0 and the most negative value to 1, as the sign bit does.
  for (genvar i = 0; i < LANES; i++) begin : g_sign
    assign tmp[LANES-1-i] = llr[(LANES-i)*LLR_W-1];
  end

  for (genvar k = 0; k < LANES; k++) begin : g_perm
    localparam int SRC = bitrev_idx(k, LG);
    assign tmp_rev[k] = tmp[SRC];
  end

  assign bits = bitrev_en ? tmp_rev : tmp;
  // Permutation does not change parity, so take it before the mux.
  assign par  = ^tmp;

endmodule

// File: rtl/func_rate1_stream.sv
// Rate-1 node processor: streams a node of LLRs in, emits hard-decided bit
// chunks through a one-deep output register, and reports node parity/done.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. valid never depends on ready; once raised, valid and its payload
// stay stable until the transfer. llr_ready may depend on bit_ready (the
// output register passes through when it is being drained).
module func_rate1_stream
  import func_rate1_stream_pkg::*;
#(
  parameter int LLR_W         = LLR_INTERNAL_LEN,
  parameter int LANES         = PROCESS_UNIT_LLR_NUM,
  parameter int MAX_NODE_LOG2 = 10,
  parameter int NL_W          = $clog2(MAX_NODE_LOG2 + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [NL_W-1:0]          node_log2,
  input  logic                     bitrev_en,
  input  logic                     llr_valid,
  output logic                     llr_ready,
  input  logic [LANES*LLR_W-1:0]   llr,
  output logic                     bit_valid,
  input  logic                     bit_ready,
  output logic [LANES-1:0]         bit_out,
  output logic [MAX_NODE_LOG2-1:0] bit_idx,
  output logic                     bit_last,
  output logic                     busy,
  output logic                     done,
  output logic                     parity,
  output logic                     cfg_err,
  output logic [1:0]               dbg_state
);

  localparam int LG   = $clog2(LANES);
  localparam int CL_W = MAX_NODE_LOG2 + 1;

  r1s_state_e               state_q, state_d;
  logic [CL_W-1:0]          chunks_left_q, chunks_left_d;
  logic [MAX_NODE_LOG2-1:0] cnt_q, cnt_d;
  logic                     par_acc_q, par_acc_d;
  logic                     bitrev_q, bitrev_d;
  logic                     bit_valid_q, bit_valid_d;
  logic [LANES-1:0]         bit_out_q, bit_out_d;
  logic [MAX_NODE_LOG2-1:0] bit_idx_q, bit_idx_d;
  logic                     bit_last_q, bit_last_d;
  logic                     done_q, done_d;
  logic                     cfg_err_q, cfg_err_d;
  logic                     parity_q, parity_d;

  logic [LANES-1:0] dec_bits;
  logic             dec_par;
  logic             rdy;
  logic             in_hs;
  logic             out_hs;
  logic             cfg_ok;

  rate1_hard_dec #(
    .LLR_W (LLR_W),
    .LANES (LANES)
  ) u_hard_dec (
    .llr       (llr),
    .bitrev_en (bitrev_q),
    .bits      (dec_bits),
    .par       (dec_par)
  );

  // Handshake qualifiers and node-size legality.
  always_comb begin
    rdy    = (state_q == R1S_RUN) && (!bit_valid_q || bit_ready);
    in_hs  = llr_valid && rdy;
    out_hs = bit_valid_q && bit_ready;
    cfg_ok = (node_log2 >= NL_W'(LG)) && (node_log2 <= NL_W'(MAX_NODE_LOG2));
  end

  // Next-state, counters, output register and parity accumulation.
  always_comb begin
    state_d       = state_q;
    chunks_left_d = chunks_left_q;
    cnt_d         = cnt_q;
    par_acc_d     = par_acc_q;
    bitrev_d      = bitrev_q;
    bit_valid_d   = bit_valid_q;
    bit_out_d     = bit_out_q;
    bit_idx_d     = bit_idx_q;
    bit_last_d    = bit_last_q;
    done_d        = 1'b0;
    cfg_err_d     = 1'b0;
    parity_d      = parity_q;
    case (state_q)
      R1S_IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            bitrev_d      = bitrev_en;
            chunks_left_d = CL_W'(1) << (node_log2 - NL_W'(LG));
            cnt_d         = '0;
            par_acc_d     = 1'b0;
            state_d       = R1S_RUN;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      R1S_RUN: begin
        if (out_hs) bit_valid_d = 1'b0;
        if (in_hs) begin
          bit_valid_d   = 1'b1;
          bit_out_d     = dec_bits;
          bit_idx_d     = cnt_q;
          bit_last_d    = (chunks_left_q == CL_W'(1));
          par_acc_d     = par_acc_q ^ dec_par;
          cnt_d         = cnt_q + 1'b1;
          chunks_left_d = chunks_left_q - 1'b1;
          if (chunks_left_q == CL_W'(1)) state_d = R1S_FLUSH;
        end
      end
      R1S_FLUSH: begin
        if (out_hs) begin
          bit_valid_d = 1'b0;
          if (bit_last_q) begin
            done_d   = 1'b1;
            parity_d = par_acc_q;
            state_d  = R1S_IDLE;
          end
        end
      end
      default: state_d = R1S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= R1S_IDLE;
      chunks_left_q <= '0;
      cnt_q         <= '0;
      par_acc_q     <= 1'b0;
      bitrev_q      <= 1'b0;
      bit_valid_q   <= 1'b0;
      bit_out_q     <= '0;
      bit_idx_q     <= '0;
      bit_last_q    <= 1'b0;
      done_q        <= 1'b0;
      cfg_err_q     <= 1'b0;
      parity_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      chunks_left_q <= chunks_left_d;
      cnt_q         <= cnt_d;
      par_acc_q     <= par_acc_d;
      bitrev_q      <= bitrev_d;
      bit_valid_q   <= bit_valid_d;
      bit_out_q     <= bit_out_d;
      bit_idx_q     <= bit_idx_d;
      bit_last_q    <= bit_last_d;
      done_q        <= done_d;
      cfg_err_q     <= cfg_err_d;
      parity_q      <= parity_d;
    end
  end

  assign llr_ready = rdy;
  assign bit_valid = bit_valid_q;
  assign bit_out   = bit_out_q;
  assign bit_idx   = bit_idx_q;
  assign bit_last  = bit_last_q;
  assign busy      = (state_q != R1S_IDLE);
  assign done      = done_q;
  assign parity    = parity_q;
  assign cfg_err   = cfg_err_q;
  assign dbg_state = state_q;

endmodule
